led_trail_pwm: RTL and testbench

- Downstream stage for the 8-bit one-hot bouncing-light position counter.
- Converts the moving one-hot position into per-LED PWM brightness with a decaying "comet" trail.
- The LED under the current position is fully on. LEDs it has left fade out in fixed steps.
- Drives the board LED pins directly. Also flags malformed (non-one-hot) position input.

---
 rtl/led_trail_pwm.sv | 62 ++++++
 tb/tb_led_trail_pwm.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/led_trail_pwm.sv
// led_trail_pwm: turns a one-hot bouncing-light position into per-LED PWM with a decaying comet trail,
// and flags any position word that is not exactly one-hot.
module led_trail_pwm #(
  parameter int PWM_BITS   = 4,
  parameter int DECAY_DIV  = 4,
  parameter int DECAY_STEP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pos,
  input  logic       err_clr,
  output logic [7:0] led,
  output logic       onehot_err
);
  localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);
  localparam logic [DW-1:0] DIV_LAST = DW'(DECAY_DIV - 1);
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [DW-1:0]       div_q, div_d;
  logic [PWM_BITS-1:0] lvl_q [8];
  logic [PWM_BITS-1:0] lvl_d [8];
  logic [7:0]          led_q, led_d;
  logic                err_q, err_d;
  logic                pwm_max, decay_tick, bad_pos;
  assign pwm_max    = pwm_q == MAX;
  assign decay_tick = pwm_max && div_q == DIV_LAST;
  assign bad_pos    = (pos == 8'h00) || ((pos & (pos - 8'd1)) != 8'h00);
  always_comb begin
    pwm_d = pwm_q + 1'b1;
    div_d = pwm_max ? ((div_q == DIV_LAST) ? '0 : div_q + 1'b1) : div_q;
    err_d = bad_pos ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end
  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_lvl
      // load beats decay; decay saturates at zero rather than wrapping
      assign lvl_d[i] = pos[i] ? MAX :
                        decay_tick ? ((lvl_q[i] > STEP) ? lvl_q[i] - STEP : '0) : lvl_q[i];
      assign led_d[i] = (lvl_q[i] == MAX) | (pwm_q < lvl_q[i]);
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) lvl_q[i] <= '0;
        else        lvl_q[i] <= lvl_d[i];
      end
    end
  endgenerate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_q <= '0;
      div_q <= '0;
      led_q <= 8'h00;
      err_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
      div_q <= div_d;
      led_q <= led_d;
      err_q <= err_d;
    end
  end
  assign led        = led_q;
  assign onehot_err = err_q;
endmodule

// File: tb/tb_led_trail_pwm.sv
// tb_led_trail_pwm: directed-vector bench for led_trail_pwm at default parameters.
module tb_led_trail_pwm;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pos = 8'h01;
  logic       err_clr = 1'b0;
  logic [7:0] led;
  logic       onehot_err;
  int vecs = 0;
  int errs = 0;
  int n = 0;
  int hi1 = 0;
  int hi7 = 0;
  int z0 = 0;

  led_trail_pwm dut (
    .clk(clk), .reset(reset), .pos(pos), .err_clr(err_clr),
    .led(led), .onehot_err(onehot_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one rising edge, then sample 1 time unit later; n counts edges since reset release
  task automatic step();
    @(posedge clk);
    #1;
    n++;
    hi1 += int'(led[1]);
    hi7 += int'(led[7]);
    z0 += int'(!led[0]);
  endtask

  task automatic go(input int target);
    while (n < target) step();
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    check("rst_led_async", 32'(led), 32'h00);
    check("rst_err_async", 32'(onehot_err), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_led_held", 32'(led), 32'h00);
    #3 reset = 1'b1;
    n = 0;
    step();
    check("led_edge1", 32'(led), 32'h00);
    step();
    check("led_edge2", 32'(led), 32'h01);
    pos = 8'h02;
    step();
    pos = 8'h01;
    hi1 = 0; z0 = 0;
    go(19);
    check("lvl1_15_duty", 32'(hi1), 32'd16);
    check("led0_steady_a", 32'(z0), 32'd0);
    go(64);
    hi1 = 0; z0 = 0;
    go(80);
    check("lvl1_11_duty", 32'(hi1), 32'd11);
    check("led0_steady_b", 32'(z0), 32'd0);
    go(128);
    hi1 = 0;
    go(144);
    check("lvl1_7_duty", 32'(hi1), 32'd7);
    go(192);
    hi1 = 0;
    go(208);
    check("lvl1_3_duty", 32'(hi1), 32'd3);
    go(256);
    hi1 = 0; z0 = 0;
    go(272);
    check("lvl1_sat0_duty", 32'(hi1), 32'd0);
    check("led0_steady_c", 32'(z0), 32'd0);
    check("led_after_fade", 32'(led), 32'h01);
    check("err_clean", 32'(onehot_err), 32'h0);
    go(300);
    pos = 8'h80;
    go(320);
    pos = 8'h01;
    hi7 = 0;
    go(336);
    check("load_beats_decay", 32'(hi7), 32'd16);
    go(400);
    pos = 8'h00;
    step();
    check("err_set_zero", 32'(onehot_err), 32'h1);
    pos = 8'h01;
    step();
    check("err_sticky_1", 32'(onehot_err), 32'h1);
    step();
    check("err_sticky_2", 32'(onehot_err), 32'h1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_cleared", 32'(onehot_err), 32'h0);
    pos = 8'h03;
    step();
    pos = 8'h01;
    check("err_set_multi", 32'(onehot_err), 32'h1);
    step();
    check("multi_load_led", 32'(led[1:0]), 32'h3);
    pos = 8'h00;
    err_clr = 1'b1;
    step();
    check("set_beats_clr", 32'(onehot_err), 32'h1);
    pos = 8'h01;
    step();
    err_clr = 1'b0;
    check("clr_valid_pos", 32'(onehot_err), 32'h0);
    go(455);
    pos = 8'h00;
    step();
    pos = 8'h01;
    check("err_before_rst", 32'(onehot_err), 32'h1);
    go(460);
    #2 reset = 1'b0;
    #1;
    check("midrst_led", 32'(led), 32'h00);
    check("midrst_err", 32'(onehot_err), 32'h0);
    pos = 8'h02;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    n = 0;
    step();
    pos = 8'h01;
    check("postrst_led1", 32'(led), 32'h00);
    go(48);
    hi1 = 0;
    go(64);
    check("postrst_pre_tick", 32'(hi1), 32'd16);
    hi1 = 0;
    go(80);
    check("postrst_tick64", 32'(hi1), 32'd11);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
